seq_4to2_encoder: RTL and testbench
===================================

Name: seq_4to2_encoder

Overview:
- Registered 4-to-2 encoder. It is the inverse of the CMOS 2-to-4 decoder: it accepts a 4-bit line vector D[3:0] and returns the 2-bit select code(s) S1:S0 that would drive those lines.
- A multi-hot vector is serialized into one code per handshake, in priority order, with a last marker on the final code.
- Sits between decoder-style select logic and any consumer of select codes, e.g. the decoder itself in loopback.

Parameters:
- LSB_FIRST, 0, priority order. 0 = highest index first (Y3 > Y2 > Y1 > Y0). 1 = lowest index first.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- D  in  4  line vector; bit i corresponds to decoder output Yi
- d_valid  in  1  D is valid
- d_ready  out  1  encoder can accept a vector (high only in IDLE)
- S  out  2  encoded select code {S1,S0}; registered
- s_valid  out  1  S is valid
- s_ready  in  1  consumer accepts S
- s_last  out  1  S is the final code of the current vector
- busy  out  1  high while in DRAIN
- err  out  1  multi-hot flag; see Optional Feature, otherwise tied 0

Behaviour:
- Reset (async assert, sync-released by the system): state=IDLE, pending=0, S=2'b00, s_valid=0, s_last=0, busy=0, err=0, d_ready=1.
- FSM states: IDLE, DRAIN.
- IDLE:
  - d_ready=1, s_valid=0.
  - On d_valid with D != 0 at edge k: pending <= D; S <= index of the priority bit of D; s_last <= (popcount(D)==1); state <= DRAIN.
  - s_valid is high in cycle k+1. Latency from acceptance to first code is 1 cycle.
- IDLE with d_valid and D == 0: the vector is consumed (handshake completes). No code is produced and the FSM stays in IDLE.
- DRAIN:
  - d_ready=0, busy=1, s_valid=1.
  - S, s_valid and s_last hold stable until s_valid && s_ready.
  - On transfer, the sent bit is cleared from pending.
  - If the remainder is nonzero: S updates next cycle to the next priority index, and s_last is recomputed (remainder popcount == 1). s_valid stays high, so back-to-back transfers occur at one code per cycle when s_ready is held high.
  - If the remainder is zero (s_last transfer): state <= IDLE, s_valid <= 0, d_ready=1 in the next cycle.
- Throughput: a k-hot vector takes k transfer cycles plus 1 IDLE cycle before the next vector is accepted.
- Encoding: S = i for the selected bit i. Examples: D=4'b0001 -> S=00; 4'b0010 -> 01; 4'b0100 -> 10; 4'b1000 -> 11.
- d_valid while in DRAIN: ignored (d_ready=0); the producer must hold the vector.
- s_ready asserted while s_valid=0: no effect.
- rst_n asserted mid-DRAIN: all outputs return to reset values immediately; pending codes are discarded.

Optional Feature:
- Macro: SEQ_ENC_MULTIHOT_ERR_EN.
- Defined:
  - err is a sticky registered flag, set when a vector with popcount(D) > 1 is accepted.
  - err is cleared on the next accepted one-hot or zero vector.
  - Serialization is unchanged.
- Undefined: err is tied to 0 and the popcount>1 compare logic is removed.

Decomposition:
- Package seq_enc_pkg:
  - enc_state_t (IDLE, DRAIN)
  - constants LINES=4, CODE_W=2
  - function popcount4
- One sub-module: prio_pick4.
  - Combinational; takes pending[3:0] and LSB_FIRST.
  - Produces idx[1:0], any, and rest[3:0] (pending with idx cleared).
  - Used both for the load path and for the drain update.

Test Plan:
- Single-hot sweep: D = 0001, 0010, 0100, 1000, each with s_ready=1 -> S = 00, 01, 10, 11 respectively; s_last=1 each time; s_valid exactly 1 cycle after acceptance.
- Multi-hot, LSB_FIRST=0: D=1011, s_ready=1 -> S sequence 11, 01, 00 on consecutive cycles; s_last only on 00; d_ready returns 1 in the cycle after the last transfer.
- Multi-hot, LSB_FIRST=1: D=0110 -> S sequence 01, 10; s_last on 10.
- Backpressure: D=1100, s_ready held 0 for 5 cycles -> S=11 and s_valid stable throughout; d_ready=0; d_valid toggling is ignored. Then s_ready=1 -> 11, then 10 with s_last.
- Zero vector and reset: D=0000 with d_valid -> no s_valid and the FSM stays in IDLE. Then D=1111 and rst_n pulsed low after the first transfer -> s_valid=0, S=00, busy=0 immediately; the next accepted D=0001 yields S=00 cleanly.
- With SEQ_ENC_MULTIHOT_ERR_EN: D=0101 -> err=1 and stays 1; a following D=0010 -> err=0 after acceptance. Without the macro, err=0 throughout.

Source files
------------

// File: rtl/seq_4to2_encoder_pkg.sv
// Shared types, widths and helpers for the sequential 4-to-2 encoder.
package seq_enc_pkg;

  localparam int unsigned LINES  = 4;
  localparam int unsigned CODE_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } enc_state_t;

  // Number of asserted lines in a 4-bit vector.
  function automatic logic [2:0] popcount4(input logic [LINES-1:0] v);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(LINES); i++) begin
      cnt = cnt + 3'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/seq_4to2_encoder_if.sv
// Line-vector input stream and select-code output stream of the encoder.
interface seq_4to2_encoder_if;
  import seq_enc_pkg::*;

  logic [LINES-1:0]  D;
  logic              d_valid;
  logic              d_ready;
  logic [CODE_W-1:0] S;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;

  modport slave (
    input  D, d_valid, s_ready,
    output d_ready, S, s_valid, s_last
  );

  modport master (
    output D, d_valid, s_ready,
    input  d_ready, S, s_valid, s_last
  );
endinterface

// File: rtl/seq_4to2_encoder_prio_pick4.sv
// Combinational priority pick: index of the winning line and the vector with it cleared.
module prio_pick4
  import seq_enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic [LINES-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic [LINES-1:0]  rest
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Later loop iterations override earlier ones, so scan order sets priority.
    if (LSB_FIRST) begin
      for (int i = int'(LINES) - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(LINES); i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
    rest = vec & ~(LINES'(1) << idx);
  end

endmodule

// File: rtl/seq_4to2_encoder.sv
// Registered 4-to-2 encoder serializing multi-hot line vectors into select codes.
// Optional sticky multi-hot flag on err: define SEQ_ENC_MULTIHOT_ERR_EN.
module seq_4to2_encoder
  import seq_enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_4to2_encoder_if.slave    bus,
  output logic                 busy,
  output logic                 err
);

  enc_state_t        state_q;
  logic [LINES-1:0]  pending_q;
  logic [CODE_W-1:0] s_q;
  logic              s_valid_q;
  logic              s_last_q;
  logic              busy_q;
  logic              d_ready_q;

  logic [CODE_W-1:0] ld_idx, dr_idx;
  logic              ld_any, dr_any;
  logic [LINES-1:0]  ld_rest, dr_rest;

  // pending_q holds only the lines still owed after the code currently on S.
  prio_pick4 #(.LSB_FIRST(LSB_FIRST)) u_pick_load (
    .vec (bus.D),
    .idx (ld_idx),
    .any (ld_any),
    .rest(ld_rest)
  );

  prio_pick4 #(.LSB_FIRST(LSB_FIRST)) u_pick_drain (
    .vec (pending_q),
    .idx (dr_idx),
    .any (dr_any),
    .rest(dr_rest)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      d_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.d_valid && ld_any) begin
            pending_q <= ld_rest;
            s_q       <= ld_idx;
            s_last_q  <= (popcount4(bus.D) == 3'd1);
            s_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            d_ready_q <= 1'b0;
            state_q   <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.s_ready) begin
            if (dr_any) begin
              s_q       <= dr_idx;
              pending_q <= dr_rest;
              s_last_q  <= (popcount4(pending_q) == 3'd1);
            end else begin
              s_valid_q <= 1'b0;
              s_last_q  <= 1'b0;
              busy_q    <= 1'b0;
              d_ready_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SEQ_ENC_MULTIHOT_ERR_EN
  logic err_q;

  // Sticky until the next accepted vector that is one-hot or zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && bus.d_valid) begin
      err_q <= (popcount4(bus.D) > 3'd1);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.S       = s_q;
  assign bus.s_valid = s_valid_q;
  assign bus.s_last  = s_last_q;
  assign bus.d_ready = d_ready_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_seq_4to2_encoder.sv
// Directed self-checking bench for seq_4to2_encoder (MSB-first and LSB-first instances).
module tb_seq_4to2_encoder;

  logic clk;
  logic rst_n;
  logic busy_m, err_m, busy_l, err_l;
  int   tests;
  int   fails;

  seq_4to2_encoder_if bus_m ();
  seq_4to2_encoder_if bus_l ();

  seq_4to2_encoder #(.LSB_FIRST(1'b0)) dut_m (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_m.slave),
    .busy (busy_m),
    .err  (err_m)
  );

  seq_4to2_encoder #(.LSB_FIRST(1'b1)) dut_l (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_l.slave),
    .busy (busy_l),
    .err  (err_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic l);
    chk({tag, ".s_valid"}, 32'(bus_m.s_valid), 32'(v));
    chk({tag, ".S"},       32'(bus_m.S),       32'(s));
    chk({tag, ".s_last"},  32'(bus_m.s_last),  32'(l));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus_m.D = '0; bus_m.d_valid = 1'b0; bus_m.s_ready = 1'b0;
    bus_l.D = '0; bus_l.d_valid = 1'b0; bus_l.s_ready = 1'b0;
    tick(); tick();

    // Reset values
    chk_out("rst", 1'b0, 2'b00, 1'b0);
    chk("rst.d_ready", 32'(bus_m.d_ready), 32'd1);
    chk("rst.busy", 32'(busy_m), 32'd0);
    chk("rst.err", 32'(err_m), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-hot sweep
    for (int i = 0; i < 4; i++) begin
      bus_m.D = 4'(1 << i); bus_m.d_valid = 1'b1; bus_m.s_ready = 1'b1;
      chk("sweep.d_ready_pre", 32'(bus_m.d_ready), 32'd1);
      tick();
      bus_m.d_valid = 1'b0;
      chk_out("sweep.code", 1'b1, 2'(i), 1'b1);
      chk("sweep.busy", 32'(busy_m), 32'd1);
      tick();
      chk("sweep.idle_valid", 32'(bus_m.s_valid), 32'd0);
      chk("sweep.idle_ready", 32'(bus_m.d_ready), 32'd1);
    end

    // Multi-hot MSB first: 1011 -> 11, 01, 00
    bus_m.D = 4'b1011; bus_m.d_valid = 1'b1; bus_m.s_ready = 1'b1;
    tick();
    bus_m.d_valid = 1'b0;
    chk_out("msb.c0", 1'b1, 2'b11, 1'b0);
    chk("msb.d_ready", 32'(bus_m.d_ready), 32'd0);
    tick();
    chk_out("msb.c1", 1'b1, 2'b01, 1'b0);
    tick();
    chk_out("msb.c2", 1'b1, 2'b00, 1'b1);
    tick();
    chk("msb.done_valid", 32'(bus_m.s_valid), 32'd0);
    chk("msb.done_ready", 32'(bus_m.d_ready), 32'd1);
    chk("msb.done_busy", 32'(busy_m), 32'd0);

    // Multi-hot LSB first: 0110 -> 01, 10
    bus_l.D = 4'b0110; bus_l.d_valid = 1'b1; bus_l.s_ready = 1'b1;
    tick();
    bus_l.d_valid = 1'b0;
    chk("lsb.c0.S", 32'(bus_l.S), 32'd1);
    chk("lsb.c0.last", 32'(bus_l.s_last), 32'd0);
    chk("lsb.c0.valid", 32'(bus_l.s_valid), 32'd1);
    tick();
    chk("lsb.c1.S", 32'(bus_l.S), 32'd2);
    chk("lsb.c1.last", 32'(bus_l.s_last), 32'd1);
    tick();
    chk("lsb.done_valid", 32'(bus_l.s_valid), 32'd0);
    chk("lsb.done_ready", 32'(bus_l.d_ready), 32'd1);

    // Backpressure: 1100 held for 5 cycles with d_valid toggling
    bus_m.D = 4'b1100; bus_m.d_valid = 1'b1; bus_m.s_ready = 1'b0;
    tick();
    bus_m.D = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      bus_m.d_valid = c[0];
      chk_out("bp.hold", 1'b1, 2'b11, 1'b0);
      chk("bp.d_ready", 32'(bus_m.d_ready), 32'd0);
      tick();
    end
    bus_m.d_valid = 1'b0; bus_m.s_ready = 1'b1;
    chk_out("bp.release", 1'b1, 2'b11, 1'b0);
    tick();
    chk_out("bp.second", 1'b1, 2'b10, 1'b1);
    tick();
    chk("bp.done_valid", 32'(bus_m.s_valid), 32'd0);
    chk("bp.done_ready", 32'(bus_m.d_ready), 32'd1);

    // Zero vector is consumed without producing a code
    bus_m.D = 4'b0000; bus_m.d_valid = 1'b1;
    tick();
    bus_m.d_valid = 1'b0;
    chk("zero.s_valid", 32'(bus_m.s_valid), 32'd0);
    chk("zero.d_ready", 32'(bus_m.d_ready), 32'd1);
    chk("zero.busy", 32'(busy_m), 32'd0);
    tick();
    chk("zero.s_valid2", 32'(bus_m.s_valid), 32'd0);

    // Reset mid-drain of 1111
    bus_m.D = 4'b1111; bus_m.d_valid = 1'b1; bus_m.s_ready = 1'b1;
    tick();
    bus_m.d_valid = 1'b0;
    chk_out("mr.c0", 1'b1, 2'b11, 1'b0);
    tick();
    chk_out("mr.c1", 1'b1, 2'b10, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("mr.rst", 1'b0, 2'b00, 1'b0);
    chk("mr.busy", 32'(busy_m), 32'd0);
    chk("mr.d_ready", 32'(bus_m.d_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr.idle_valid", 32'(bus_m.s_valid), 32'd0);
    bus_m.D = 4'b0001; bus_m.d_valid = 1'b1;
    tick();
    bus_m.d_valid = 1'b0;
    chk_out("mr.after", 1'b1, 2'b00, 1'b1);
    tick();
    chk("mr.after_idle", 32'(bus_m.s_valid), 32'd0);

    // Multi-hot error flag
    bus_m.D = 4'b0101; bus_m.d_valid = 1'b1; bus_m.s_ready = 1'b0;
    tick();
    bus_m.d_valid = 1'b0;
`ifdef SEQ_ENC_MULTIHOT_ERR_EN
    chk("err.set", 32'(err_m), 32'd1);
`else
    chk("err.off_a", 32'(err_m), 32'd0);
`endif
    bus_m.s_ready = 1'b1;
    tick();
    tick();
    chk("err.drained", 32'(bus_m.s_valid), 32'd0);
`ifdef SEQ_ENC_MULTIHOT_ERR_EN
    chk("err.sticky", 32'(err_m), 32'd1);
`else
    chk("err.off_b", 32'(err_m), 32'd0);
`endif
    bus_m.D = 4'b0010; bus_m.d_valid = 1'b1;
    tick();
    bus_m.d_valid = 1'b0;
    chk_out("err.onehot", 1'b1, 2'b01, 1'b1);
    chk("err.clear", 32'(err_m), 32'd0);
    chk("err.lsb_inst", 32'(err_l), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time guard so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
